// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction fetch front end. Owns the PC and issues AXI4-Lite reads with
//   up to MAX_OUTSTANDING fetches in flight or queued. Returned words are queued
//   in order with their PCs and handed to decode on a valid/ready stream.
//   A redirect flushes the queue and discards responses still on the bus. A
//   faulting response halts issue until the next redirect.
//
// Ports
//   clk, rstn                       clock, async active-low reset
//   o_im_ar{valid,addr,prot}, i_im_arready     AXI4-Lite AR channel
//   i_im_r{valid,data,resp}, o_im_rready       AXI4-Lite R channel
//   i_redirect_valid/addr           single-cycle PC redirect
//   o_inst_{valid,data,pc,fault}, i_inst_ready decode stream
//   o_perf_dropped                  stale-response count (FETCH_PERF_EN only)
//
// Build option
//   FETCH_PERF_EN : adds the saturating o_perf_dropped counter port.

module fetch_prefetch_unit #(
  parameter int               XLEN            = 32,
  parameter logic [XLEN-1:0]  RESET_ADDR      = '0,
  parameter int               MAX_OUTSTANDING = 4,
  parameter logic [2:0]       FETCH_PROT      = 3'b100
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            o_im_arvalid,
  input  logic            i_im_arready,
  output logic [XLEN-1:0] o_im_araddr,
  output logic [2:0]      o_im_arprot,
  input  logic            i_im_rvalid,
  output logic            o_im_rready,
  input  logic [31:0]     i_im_rdata,
  input  logic [1:0]      i_im_rresp,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_addr,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [31:0]     o_inst_data,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_dropped
`endif
);

  localparam int            CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int            PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [31:0]     data;
    logic [XLEN-1:0] pc;
    logic            fault;
  } ent_t;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   credit, credit_next;
  logic [CW-1:0]   drop, drop_next;
  logic [CW-1:0]   out_cnt, out_next;   // accepted ARs awaiting a response
  logic [CW-1:0]   q_cnt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [XLEN-1:0] pc;                  // address of the next AR to launch
  logic [XLEN-1:0] pc_eff;
  logic [XLEN-1:0] resp_pc;             // PC of the next non-stale response
  logic [XLEN-1:0] redir_addr;
  ent_t            q_mem [MAX_OUTSTANDING];
  logic            ar_hs, ar_held, rsp, rsp_drop, push, pop, issue, redirect;
  logic            unused_redir_lsb;

  assign o_im_arprot      = FETCH_PROT;
  assign redirect         = i_redirect_valid;
  assign redir_addr       = {i_redirect_addr[XLEN-1:2], 2'b00};
  assign unused_redir_lsb = ^i_redirect_addr[1:0];

  assign o_inst_valid = (q_cnt != '0);
  assign o_inst_data  = q_mem[rd_ptr].data;
  assign o_inst_pc    = q_mem[rd_ptr].pc;
  assign o_inst_fault = q_mem[rd_ptr].fault;

  always_comb begin
    ar_hs    = o_im_arvalid & i_im_arready;
    ar_held  = o_im_arvalid & ~i_im_arready;
    rsp      = i_im_rvalid & o_im_rready;
    rsp_drop = rsp & (drop != '0);
    // A redirect in the same cycle kills both the push and the pop.
    push     = rsp & (drop == '0) & ~redirect;
    pop      = o_inst_valid & i_inst_ready & ~redirect;
    out_next = out_cnt + CW'(ar_hs) - CW'(rsp);
    pc_eff   = redirect ? redir_addr : pc;

    state_next = state;
    if (redirect)
      state_next = ST_RUN;
    else if (push && (i_im_rresp != 2'b00))
      state_next = ST_HALT;

    if (redirect) begin
      // A still-pending AR is counted in drop but not yet in credit: credit
      // picks it up through the normal handshake increment, so the pair stays
      // consistent with "credit = drop" once that AR is accepted.
      credit_next = out_next;
      drop_next   = out_next + CW'(ar_held);
    end else begin
      credit_next = credit + CW'(ar_hs) - CW'(pop) - CW'(rsp_drop);
      drop_next   = drop - CW'(rsp_drop);
    end

    issue = (state_next == ST_RUN) && (credit_next < CMAX);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_RUN;
      credit       <= '0;
      drop         <= '0;
      out_cnt      <= '0;
      o_im_arvalid <= 1'b0;
      o_im_araddr  <= RESET_ADDR;
      o_im_rready  <= 1'b0;
      pc           <= RESET_ADDR;
      resp_pc      <= RESET_ADDR;
      q_cnt        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) q_mem[i] <= '0;
    end else begin
      o_im_rready <= 1'b1;  // credit bounds the queue, so R never stalls
      state       <= state_next;
      credit      <= credit_next;
      drop        <= drop_next;
      out_cnt     <= out_next;

      // AR holds address/valid until accepted; a new AR launches from pc_eff,
      // so a redirect during a stalled AR only affects the following one.
      o_im_arvalid <= ar_held | issue;
      if (!ar_held && issue) begin
        o_im_araddr <= pc_eff;
        pc          <= pc_eff + XLEN'(4);
      end else if (redirect) begin
        pc <= redir_addr;
      end

      if (redirect)
        resp_pc <= redir_addr;
      else if (push)
        resp_pc <= resp_pc + XLEN'(4);

      if (redirect) begin
        q_cnt  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          q_mem[wr_ptr] <= '{data: i_im_rdata, pc: resp_pc, fault: (i_im_rresp != 2'b00)};
          wr_ptr        <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      o_perf_dropped <= '0;
    else if (rsp_drop && (o_perf_dropped != 32'hFFFF_FFFF))
      o_perf_dropped <= o_perf_dropped + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a memory slave answering one cycle
// after each AR, a decode-side monitor, a table of expected instruction
// streams and hand-written sequences for backpressure, redirect, fault and
// reset corner cases.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        im_arvalid, im_arready, im_rvalid, im_rready;
  logic [31:0] im_araddr, im_rdata;
  logic [2:0]  im_arprot;
  logic [1:0]  im_rresp;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst_data, inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .clk              (clk),
    .rstn             (rstn),
    .o_im_arvalid     (im_arvalid),
    .i_im_arready     (im_arready),
    .o_im_araddr      (im_araddr),
    .o_im_arprot      (im_arprot),
    .i_im_rvalid      (im_rvalid),
    .o_im_rready      (im_rready),
    .i_im_rdata       (im_rdata),
    .i_im_rresp       (im_rresp),
    .i_redirect_valid (redirect_valid),
    .i_redirect_addr  (redirect_addr),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst_data      (inst_data),
    .o_inst_pc        (inst_pc),
    .o_inst_fault     (inst_fault)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_dropped   (perf_dropped)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } ent_t;

  typedef struct {
    int          tid;
    logic [31:0] pc;
    logic        fault;
  } vec_t;

  localparam logic [31:0] NO_FAULT = 32'hFFFF_FFFC;

  // slave/test controls (written only by the test process)
  logic [31:0] fault_addr = NO_FAULT;
  int          resp_limit = 1000000;

  // slave/monitor state (written only by the slave process)
  logic [31:0] pend[$];
  logic [31:0] ar_log[$];
  ent_t        rx[$];
  int          resp_sent;
  logic [31:0] sa;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // Slave and monitor act on the falling edge; the test drives after the
  // rising edge, so neither races the DUT or each other.
  always @(negedge clk) begin
    if (!rstn) begin
      pend.delete();
      ar_log.delete();
      rx.delete();
      resp_sent = 0;
      im_rvalid = 1'b0;
      im_rdata  = '0;
      im_rresp  = 2'b00;
    end else begin
      im_rvalid = 1'b0;
      if (pend.size() > 0 && resp_sent < resp_limit) begin
        sa        = pend.pop_front();
        im_rvalid = 1'b1;
        im_rdata  = mem_word(sa);
        im_rresp  = (sa == fault_addr) ? 2'b10 : 2'b00;
        resp_sent = resp_sent + 1;
      end
      if (im_arvalid && im_arready) begin
        pend.push_back(im_araddr);
        ar_log.push_back(im_araddr);
      end
      if (inst_valid && inst_ready)
        rx.push_back('{pc: inst_pc, data: inst_data, fault: inst_fault});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic ar, input logic ir, input int lim, input logic [31:0] fa);
    @(posedge clk);
    #1;
    rstn           = 1'b0;
    im_arready     = ar;
    inst_ready     = ir;
    resp_limit     = lim;
    fault_addr     = fa;
    redirect_valid = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic wait_rx(input string nm, input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  // Compare received entries, starting at rx[base], against table rows of tid.
  task automatic check_stream(input int tid, input int base);
    int k = base;
    foreach (vecs[i]) begin
      if (vecs[i].tid == tid) begin
        if (k < rx.size()) begin
          chk($sformatf("t%0d[%0d].pc", tid, k),    rx[k].pc,    vecs[i].pc);
          chk($sformatf("t%0d[%0d].data", tid, k),  rx[k].data,  mem_word(vecs[i].pc));
          chk($sformatf("t%0d[%0d].fault", tid, k), 32'(rx[k].fault), 32'(vecs[i].fault));
        end else begin
          chk($sformatf("t%0d[%0d].present", tid, k), 32'd0, 32'd1);
        end
        k++;
      end
    end
  endtask

  initial begin
    // expected decode streams: {test id, pc, fault}
    vecs.push_back('{1, 32'h0, 1'b0});   vecs.push_back('{1, 32'h4, 1'b0});
    vecs.push_back('{1, 32'h8, 1'b0});   vecs.push_back('{1, 32'hC, 1'b0});
    for (int i = 0; i < 8; i++) vecs.push_back('{2, 32'(i * 4), 1'b0});
    vecs.push_back('{3, 32'h100, 1'b0}); vecs.push_back('{3, 32'h104, 1'b0});
    vecs.push_back('{4, 32'h0, 1'b0});   vecs.push_back('{4, 32'h4, 1'b0});
    vecs.push_back('{4, 32'h8, 1'b1});   vecs.push_back('{4, 32'hC, 1'b0});
    vecs.push_back('{5, 32'h40, 1'b0});  vecs.push_back('{5, 32'h44, 1'b0});
    vecs.push_back('{6, 32'h0, 1'b0});   vecs.push_back('{6, 32'h4, 1'b0});
    vecs.push_back('{6, 32'h8, 1'b0});   vecs.push_back('{6, 32'hC, 1'b0});
    vecs.push_back('{7, 32'h200, 1'b0}); vecs.push_back('{7, 32'h204, 1'b0});
    vecs.push_back('{8, 32'h0, 1'b0});   vecs.push_back('{8, 32'h4, 1'b0});

    im_arready     = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;

    // reset state
    #1 rstn = 1'b0;
    #2;
    chk("rst.arvalid",    32'(im_arvalid), 32'd0);
    chk("rst.araddr",     im_araddr,       32'h0);
    chk("rst.rready",     32'(im_rready),  32'd0);
    chk("rst.inst_valid", 32'(inst_valid), 32'd0);
    chk("rst.inst_data",  inst_data,       32'h0);
    chk("rst.inst_pc",    inst_pc,         32'h0);
    chk("rst.inst_fault", 32'(inst_fault), 32'd0);
    chk("arprot",         32'(im_arprot),  32'd4);
`ifdef FETCH_PERF_EN
    chk("rst.perf",       perf_dropped,    32'd0);
`endif

    // 1: sequential fetch
    do_reset(1'b1, 1'b1, 1000000, NO_FAULT);
    chk("t1.first_arvalid", 32'(im_arvalid), 32'd1);
    chk("t1.first_araddr",  im_araddr,       32'h0);
    chk("t1.rready",        32'(im_rready),  32'd1);
    wait_rx("t1.rx_count", 4, 40);
    check_stream(1, 0);

    // 2: backpressure, then resume
    do_reset(1'b1, 1'b0, 1000000, NO_FAULT);
    tick(20);
    chk("t2.ar_count",   32'(ar_log.size()), 32'd4);
    chk("t2.arvalid_lo", 32'(im_arvalid),    32'd0);
    chk("t2.inst_valid", 32'(inst_valid),    32'd1);
    chk("t2.head_pc",    inst_pc,            32'h0);
    inst_ready = 1'b1;
    tick(1);
    chk("t2.arvalid_resume", 32'(im_arvalid), 32'd1);
    chk("t2.araddr_resume",  im_araddr,       32'h10);
    wait_rx("t2.rx_count", 8, 60);
    check_stream(2, 0);

    // 3: redirect with two responses in flight and credit full
    do_reset(1'b1, 1'b0, 2, NO_FAULT);
    tick(15);
    chk("t3.arvalid_full", 32'(im_arvalid), 32'd0);
    chk("t3.inst_valid",   32'(inst_valid), 32'd1);
    pulse_redirect(32'h103);
    chk("t3.flush",        32'(inst_valid), 32'd0);
    chk("t3.araddr_redir", im_araddr,       32'h100);
    inst_ready = 1'b1;
    resp_limit = 1000000;
    wait_rx("t3.rx_count", 2, 40);
    check_stream(3, 0);
`ifdef FETCH_PERF_EN
    chk("t3.perf", perf_dropped, 32'd2);
`endif

    // 4: bus fault at 0x8 halts issue; redirect resumes
    do_reset(1'b1, 1'b1, 1000000, 32'h8);
    tick(30);
    chk("t4.ar_count", 32'(ar_log.size()), 32'd4);
    chk("t4.halted",   32'(im_arvalid),    32'd0);
    chk("t4.rx_count", 32'(rx.size()),     32'd4);
    check_stream(4, 0);
    fault_addr = NO_FAULT;
    pulse_redirect(32'h40);
    wait_rx("t4.rx_resume", 6, 40);
    check_stream(5, 4);

    // 5: redirect while an AR is stalled at 0x10
    do_reset(1'b1, 1'b1, 1000000, NO_FAULT);
    begin
      int k = 0;
      while (ar_log.size() < 4 && k < 20) begin
        tick(1);
        k++;
      end
    end
    im_arready = 1'b0;
    tick(3);
    chk("t5.stall_araddr", im_araddr,       32'h10);
    chk("t5.stall_valid",  32'(im_arvalid), 32'd1);
    pulse_redirect(32'h200);
    chk("t5.hold_araddr",  im_araddr,       32'h10);
    tick(2);
    chk("t5.hold_araddr2", im_araddr,       32'h10);
    chk("t5.hold_valid",   32'(im_arvalid), 32'd1);
    im_arready = 1'b1;
    wait_rx("t5.rx_count", 6, 40);
    check_stream(6, 0);
    check_stream(7, 4);
    chk("t5.ar_count_ok", 32'(ar_log.size() >= 6), 32'd1);
    if (ar_log.size() >= 6) begin
      chk("t5.ar_stale", ar_log[4], 32'h10);
      chk("t5.ar_new",   ar_log[5], 32'h200);
    end
`ifdef FETCH_PERF_EN
    chk("t5.perf", perf_dropped, 32'd1);
`endif

    // 6: asynchronous reset with three entries queued
    do_reset(1'b1, 1'b0, 3, NO_FAULT);
    tick(15);
    chk("t6.inst_valid", 32'(inst_valid), 32'd1);
    chk("t6.arvalid_lo", 32'(im_arvalid), 32'd0);
    rstn = 1'b0;
    #1;
    chk("t6.async_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6.async_arvalid",    32'(im_arvalid), 32'd0);
    chk("t6.async_rready",     32'(im_rready),  32'd0);
    chk("t6.async_araddr",     im_araddr,       32'h0);
    resp_limit = 1000000;
    tick(2);
    rstn = 1'b1;
    tick(1);
    chk("t6.rel_arvalid", 32'(im_arvalid), 32'd1);
    chk("t6.rel_araddr",  im_araddr,       32'h0);
    inst_ready = 1'b1;
    wait_rx("t6.rx_count", 2, 30);
    check_stream(8, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
